// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one pipelined signed Q(12.4) multiplier between
// N_REQ requesters; each result returns tagged (one-hot) after LAT cycles.
module mult_arbiter #(
    parameter int N_REQ     = 4,
    parameter int FRAC_BITS = 4,
    parameter int LAT       = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [N_REQ-1:0]      req,
    input  logic [16*N_REQ-1:0]   a_flat,
    input  logic [16*N_REQ-1:0]   b_flat,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [15:0]           rsp_data,
    output logic                  busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]       rr_ptr_r;
    logic [PW-1:0]       rr_next_s;
    logic [15:0]         a_sel_s;
    logic [15:0]         b_sel_s;
    logic                found_s;
    logic signed [31:0]  prod_s;
    logic                busy_next_s;
    logic [N_REQ-1:0]    tag_r  [LAT];
    logic signed [31:0]  prod_r [LAT];

    // Round-robin scan starting at rr_ptr_r; the granted requester's operands are muxed out.
    always_comb begin
        gnt       = '0;
        rr_next_s = rr_ptr_r;
        a_sel_s   = 16'd0;
        b_sel_s   = 16'd0;
        found_s   = 1'b0;
        if (en && !reset) begin
            for (int k = 0; k < N_REQ; k++) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (!found_s && req[i] &&
                        ((int'(rr_ptr_r) + k == i) || (int'(rr_ptr_r) + k == i + N_REQ))) begin
                        found_s   = 1'b1;
                        gnt[i]    = 1'b1;
                        rr_next_s = PW'((i + 1) % N_REQ);
                        a_sel_s   = a_flat[16*i +: 16];
                        b_sel_s   = b_flat[16*i +: 16];
                    end else begin
                        found_s   = found_s;
                    end
                end
            end
        end else begin
            gnt = '0;
        end
    end

    // Sign-extended product; idle cycles multiply zeros so rsp_data rests at 0.
    always_comb begin
        prod_s = $signed({{16{a_sel_s[15]}}, a_sel_s}) * $signed({{16{b_sel_s[15]}}, b_sel_s});
    end

    // busy is registered from the next-state occupancy of every pipeline stage.
    always_comb begin
        busy_next_s = |gnt;
        for (int s = 0; s < LAT - 1; s++) begin
            busy_next_s = busy_next_s | (|tag_r[s]);
        end
    end

    // Arbiter pointer, product/tag pipeline and busy flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_r <= '0;
            busy     <= 1'b0;
            for (int s = 0; s < LAT; s++) begin
                tag_r[s]  <= '0;
                prod_r[s] <= 32'sd0;
            end
        end else begin
            rr_ptr_r  <= rr_next_s;
            busy      <= busy_next_s;
            tag_r[0]  <= gnt;
            prod_r[0] <= prod_s;
            for (int s = 1; s < LAT; s++) begin
                tag_r[s]  <= tag_r[s-1];
                prod_r[s] <= prod_r[s-1];
            end
        end
    end

    assign rsp_valid = tag_r[LAT-1];
    // Arithmetic shift back to Q(12.4), then plain truncation: overflow wraps.
    assign rsp_data  = 16'(prod_r[LAT-1] >>> FRAC_BITS);

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: grants checked every cycle against a
// round-robin model, responses popped from an expectation queue by a monitor.
module tb_mult_arbiter;

    localparam int N   = 4;
    localparam int LAT = 2;
    localparam int F   = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              en = 1'b0;
    logic [N-1:0]      req = '0;
    logic [16*N-1:0]   a_flat = '0;
    logic [16*N-1:0]   b_flat = '0;
    logic [N-1:0]      gnt;
    logic [N-1:0]      rsp_valid;
    logic [15:0]       rsp_data;
    logic              busy;

    mult_arbiter #(.N_REQ(N), .FRAC_BITS(F), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .en(en), .req(req),
        .a_flat(a_flat), .b_flat(b_flat),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] oh;
        logic [15:0]  data;
        int           due;
    } exp_t;

    exp_t          sb[$];
    int            cyc = 0;
    int            compared = 0;
    int            mismatched = 0;
    int            mptr = 0;
    logic [LAT-1:0] ghist = '0;
    logic [15:0]   dtab [N];
    logic [N-1:0]  g;
    logic          b;

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: every cycle either the due expectation or silence.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            compared++;
            if (e.due != cyc || rsp_valid !== e.oh || rsp_data !== e.data) begin
                mismatched++;
                $display("FAIL rsp: cyc %0d got valid=%b data=%h, expected cyc %0d valid=%b data=%h",
                         cyc, rsp_valid, rsp_data, e.due, e.oh, e.data);
            end
        end else begin
            compared++;
            if (rsp_valid !== '0) begin
                mismatched++;
                $display("FAIL spurious_rsp: cyc %0d got valid=%b, expected 0", cyc, rsp_valid);
            end
        end
    end

    function automatic logic [15:0] model_mul(input logic [15:0] a, input logic [15:0] bb);
        logic signed [31:0] p;
        p = 32'($signed(a)) * 32'($signed(bb));
        p = p >>> F;
        return p[15:0];
    endfunction

    task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] bb);
        a_flat[16*i +: 16] = a;
        b_flat[16*i +: 16] = bb;
    endtask

    // One clock cycle: drive, check gnt/busy against the model, push expectation.
    task automatic step(input logic [N-1:0] r, input logic e, input logic rs,
                        output logic [N-1:0] g_out, output logic b_out);
        logic [N-1:0] eg;
        int gi;
        int idx;
        req = r; en = e; reset = rs;
        #1;
        eg = '0;
        gi = 0;
        if (e && !rs) begin
            for (int k = 0; k < N; k++) begin
                idx = (mptr + k) % N;
                if (eg == '0 && r[idx]) begin
                    eg[idx] = 1'b1;
                    gi = idx;
                end
            end
        end
        compared++;
        if (gnt !== eg) begin
            mismatched++;
            $display("FAIL gnt: cyc %0d got %b, expected %b", cyc, gnt, eg);
        end
        compared++;
        if (busy !== (rs ? 1'b0 : |ghist)) begin
            mismatched++;
            $display("FAIL busy: cyc %0d got %b, expected %b", cyc, busy, (rs ? 1'b0 : |ghist));
        end
        if (rs) begin
            sb.delete();
            ghist = '0;
            mptr = 0;
        end else begin
            ghist = {ghist[LAT-2:0], |eg};
            if (|eg) begin
                exp_t x;
                x.oh = eg; x.data = dtab[gi]; x.due = cyc + LAT;
                sb.push_back(x);
                mptr = (gi + 1) % N;
            end
        end
        g_out = gnt;
        b_out = busy;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b1, 1'b0, g, b);
    endtask

    task automatic test_reset();
        step(4'b1111, 1'b1, 1'b1, g, b);
        compared++;
        if (rsp_valid !== 4'b0000 || rsp_data !== 16'h0000) begin
            mismatched++;
            $display("FAIL reset_outputs: got valid=%b data=%h, expected 0000/0000", rsp_valid, rsp_data);
        end
        step(4'b1111, 1'b1, 1'b1, g, b);
        step(4'b0000, 1'b1, 1'b0, g, b);
    endtask

    task automatic test_single();
        set_ops(0, 16'd16, 16'd32);
        dtab[0] = 16'd32;
        step(4'b0001, 1'b1, 1'b0, g, b);
        compared++;
        if (g !== 4'b0001) begin mismatched++; $display("FAIL single_gnt: got %b, expected 0001", g); end
        idle(3);
    endtask

    task automatic test_negative();
        set_ops(1, 16'hFFE8, 16'd40);
        dtab[1] = 16'hFFC4;
        step(4'b0010, 1'b1, 1'b0, g, b);
        compared++;
        if (g !== 4'b0010) begin mismatched++; $display("FAIL neg_gnt: got %b, expected 0010", g); end
        idle(3);
    endtask

    task automatic test_round_robin();
        logic [N-1:0] gseq [5];
        gseq[0] = 4'b0001; gseq[1] = 4'b0010; gseq[2] = 4'b0100;
        gseq[3] = 4'b1000; gseq[4] = 4'b0001;
        step('0, 1'b1, 1'b1, g, b);
        step('0, 1'b1, 1'b0, g, b);
        for (int i = 0; i < N; i++) set_ops(i, 16'(16 * (i + 1)), 16'd32);
        dtab[0] = 16'd32; dtab[1] = 16'd64; dtab[2] = 16'd96; dtab[3] = 16'd128;
        for (int c = 0; c < 5; c++) begin
            step(4'b1111, 1'b1, 1'b0, g, b);
            compared++;
            if (g !== gseq[c]) begin
                mismatched++;
                $display("FAIL rr_seq[%0d]: got %b, expected %b", c, g, gseq[c]);
            end
        end
        idle(3);
    endtask

    task automatic test_wrap();
        set_ops(2, 16'h7FFF, 16'h7FFF);
        dtab[2] = 16'hF000;
        step(4'b0100, 1'b1, 1'b0, g, b);
        compared++;
        if (g !== 4'b0100) begin mismatched++; $display("FAIL wrap_gnt: got %b, expected 0100", g); end
        idle(3);
    endtask

    task automatic test_en();
        logic bexp [3];
        bexp[0] = 1'b1; bexp[1] = 1'b1; bexp[2] = 1'b0;
        step(4'b1111, 1'b1, 1'b0, g, b);
        step(4'b1111, 1'b1, 1'b0, g, b);
        for (int c = 0; c < 3; c++) begin
            step(4'b1111, 1'b0, 1'b0, g, b);
            compared++;
            if (g !== 4'b0000 || b !== bexp[c]) begin
                mismatched++;
                $display("FAIL en_gate[%0d]: got gnt=%b busy=%b, expected 0000/%b", c, g, b, bexp[c]);
            end
        end
        idle(2);
    endtask

    task automatic test_reset_mid();
        set_ops(1, 16'h0030, 16'h0020);
        dtab[1] = 16'd96;
        step(4'b0010, 1'b1, 1'b0, g, b);
        step(4'b0000, 1'b1, 1'b1, g, b);
        step(4'b0000, 1'b1, 1'b1, g, b);
        step(4'b1010, 1'b1, 1'b0, g, b);
        compared++;
        if (g !== 4'b0010) begin mismatched++; $display("FAIL post_reset_gnt: got %b, expected 0010", g); end
        step(4'b1010, 1'b1, 1'b0, g, b);
        compared++;
        if (g !== 4'b1000) begin mismatched++; $display("FAIL post_reset_gnt2: got %b, expected 1000", g); end
        idle(3);
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, bb;
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < N; i++) begin
                a  = 16'($urandom);
                bb = 16'($urandom);
                set_ops(i, a, bb);
                dtab[i] = model_mul(a, bb);
            end
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), 1'b0, g, b);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_negative();
        test_round_robin();
        test_wrap();
        test_en();
        test_reset_mid();
        test_back_to_back();
        for (int i = 0; i < 10 && sb.size() > 0; i++) idle(1);
        idle(2);
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
